// File: rtl/text_mode_pkg.sv
// Shared text-mode definitions: screen geometry, RAM address packing,
// control codes, attribute fields and writer/cursor enums.
package text_mode_pkg;

    localparam int unsigned TEXT_COLS = 80;
    localparam int unsigned TEXT_ROWS = 25;
    localparam int unsigned COL_W     = 7;
    localparam int unsigned ROW_W     = 5;
    localparam int unsigned ADDR_W    = ROW_W + COL_W;
    localparam int unsigned CHAR_W    = 8;

    localparam logic [CHAR_W-1:0] CC_BS      = 8'h08;
    localparam logic [CHAR_W-1:0] CC_LF      = 8'h0A;
    localparam logic [CHAR_W-1:0] CC_FF      = 8'h0C;
    localparam logic [CHAR_W-1:0] CC_CR      = 8'h0D;
    localparam logic [CHAR_W-1:0] BLANK_CHAR = 8'h20;

    // Attribute byte: {fg_intensity, fg_rgb[2:0], bg_intensity, bg_rgb[2:0]}
    localparam int unsigned ATTR_FG_I      = 7;
    localparam int unsigned ATTR_FG_RGB_HI = 6;
    localparam int unsigned ATTR_FG_RGB_LO = 4;
    localparam int unsigned ATTR_BG_I      = 3;
    localparam int unsigned ATTR_BG_RGB_HI = 2;
    localparam int unsigned ATTR_BG_RGB_LO = 0;

    typedef struct packed {
        logic [CHAR_W-1:0] ch;
        logic [CHAR_W-1:0] attr;
    } text_cell_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR_LINE,
        ST_CLEAR_SCREEN
    } writer_state_e;

    typedef enum logic [2:0] {
        CUR_NONE,
        CUR_ADVANCE,
        CUR_CR,
        CUR_BS,
        CUR_LF,
        CUR_HOME
    } cursor_op_e;

    function automatic logic [ADDR_W-1:0] pack_addr(input logic [ROW_W-1:0] row,
                                                     input logic [COL_W-1:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/text_cursor.sv
// Cursor column/row counters with advance, CR, BS, LF and home operations.
module text_cursor
    import text_mode_pkg::*;
#(
    parameter int unsigned COLS = TEXT_COLS,
    parameter int unsigned ROWS = TEXT_ROWS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  cursor_op_e       op,
    output logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] row,
    output logic             eol_c,
    output logic [ROW_W-1:0] next_row_c
);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

    // Row a line feed or end-of-line advance moves to; last row wraps to the top.
    always_comb begin
        eol_c      = (col == COL_LAST);
        next_row_c = (row == ROW_LAST) ? '0 : row + ROW_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else begin
            case (op)
                CUR_ADVANCE: begin
                    if (eol_c) begin
                        col <= '0;
                        row <= next_row_c;
                    end else begin
                        col <= col + COL_W'(1);
                    end
                end
                CUR_CR: col <= '0;
                CUR_BS: begin
                    if (col != '0) begin
                        col <= col - COL_W'(1);
                    end
                end
                CUR_LF: begin
                    col <= '0;
                    row <= next_row_c;
                end
                CUR_HOME: begin
                    col <= '0;
                    row <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/text_console_writer.sv
// Character-stream writer for the text-mode screen/colour RAMs: handles
// printable characters, BS/LF/CR/FF, cursor tracking and blank fills.
module text_console_writer #(
    parameter int unsigned COLS           = 80,
    parameter int unsigned ROWS           = 25,
    parameter logic [7:0]  BLANK          = 8'h20,
    parameter logic [7:0]  DEFAULT_ATTR   = 8'h70,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        char_valid,
    output logic        char_ready,
    input  logic [7:0]  char_data,
    input  logic [7:0]  char_attr,
    output logic [11:0] wr_addr,
    output logic [7:0]  scr_data,
    output logic        scr_wren,
    output logic [7:0]  col_data,
    output logic        col_wren,
    output logic [6:0]  cursor_x,
    output logic [4:0]  cursor_y,
    output logic        busy
);

    import text_mode_pkg::*;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
    localparam writer_state_e    ST_RESET = CLEAR_ON_RESET ? ST_CLEAR_SCREEN : ST_IDLE;

    writer_state_e     state, state_nxt;
    logic [ROW_W-1:0]  clr_row, clr_row_nxt;
    logic [COL_W-1:0]  clr_col, clr_col_nxt;
    logic [7:0]        clear_attr, clear_attr_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    text_cell_t        cell_nxt;
    logic              wren_nxt;

    cursor_op_e        cur_op;
    logic              cur_eol_c;
    logic [ROW_W-1:0]  cur_next_row_c;

    text_cursor #(
        .COLS (COLS),
        .ROWS (ROWS)
    ) u_cursor (
        .clk        (clk),
        .rst_n      (rst_n),
        .op         (cur_op),
        .col        (cursor_x),
        .row        (cursor_y),
        .eol_c      (cur_eol_c),
        .next_row_c (cur_next_row_c)
    );

    assign char_ready = (state == ST_IDLE);
    assign busy       = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_RESET;
            clr_row    <= '0;
            clr_col    <= '0;
            clear_attr <= DEFAULT_ATTR;
            wr_addr    <= '0;
            scr_data   <= '0;
            col_data   <= '0;
            scr_wren   <= 1'b0;
            col_wren   <= 1'b0;
        end else begin
            state      <= state_nxt;
            clr_row    <= clr_row_nxt;
            clr_col    <= clr_col_nxt;
            clear_attr <= clear_attr_nxt;
            wr_addr    <= addr_nxt;
            scr_data   <= cell_nxt.ch;
            col_data   <= cell_nxt.attr;
            scr_wren   <= wren_nxt;
            col_wren   <= wren_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        clr_row_nxt    = clr_row;
        clr_col_nxt    = clr_col;
        clear_attr_nxt = clear_attr;
        addr_nxt       = wr_addr;
        cell_nxt       = '{ch: scr_data, attr: col_data};
        wren_nxt       = 1'b0;
        cur_op         = CUR_NONE;

        unique case (state)
            ST_IDLE: begin
                if (char_valid) begin
                    clear_attr_nxt = char_attr;
                    case (char_data)
                        CC_BS: cur_op = CUR_BS;
                        CC_CR: cur_op = CUR_CR;
                        CC_LF: begin
                            cur_op      = CUR_LF;
                            state_nxt   = ST_CLEAR_LINE;
                            clr_row_nxt = cur_next_row_c;
                            clr_col_nxt = '0;
                        end
                        CC_FF: begin
                            cur_op      = CUR_HOME;
                            state_nxt   = ST_CLEAR_SCREEN;
                            clr_row_nxt = '0;
                            clr_col_nxt = '0;
                        end
                        default: begin
                            // Write at the pre-advance cursor, then step it.
                            cur_op   = CUR_ADVANCE;
                            wren_nxt = 1'b1;
                            addr_nxt = pack_addr(cursor_y, cursor_x);
                            cell_nxt = '{ch: char_data, attr: char_attr};
                            if (cur_eol_c) begin
                                state_nxt   = ST_CLEAR_LINE;
                                clr_row_nxt = cur_next_row_c;
                                clr_col_nxt = '0;
                            end
                        end
                    endcase
                end
            end
            ST_CLEAR_LINE, ST_CLEAR_SCREEN: begin
                wren_nxt = 1'b1;
                addr_nxt = pack_addr(clr_row, clr_col);
                cell_nxt = '{ch: BLANK, attr: clear_attr};
                // Row-major sweep; a line clear ends at its last column.
                if (clr_col == COL_LAST) begin
                    clr_col_nxt = '0;
                    if (state == ST_CLEAR_LINE || clr_row == ROW_LAST) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        clr_row_nxt = clr_row + ROW_W'(1);
                    end
                end else begin
                    clr_col_nxt = clr_col + COL_W'(1);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_text_console_writer.sv
// Directed bench for text_console_writer: reset clear, character table,
// end-of-line wrap, LF/CR/BS, and reset during a screen clear.
module tb_text_console_writer;

    typedef struct {
        logic [7:0]  ch;
        logic [7:0]  attr;
        logic        exp_wren;
        logic [11:0] exp_addr;
        logic [7:0]  exp_data;
        logic [7:0]  exp_attr;
        logic [6:0]  exp_x;
        logic [4:0]  exp_y;
        logic        exp_ready;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        char_valid;
    logic        char_ready;
    logic [7:0]  char_data;
    logic [7:0]  char_attr;
    logic [11:0] wr_addr;
    logic [7:0]  scr_data;
    logic        scr_wren;
    logic [7:0]  col_data;
    logic        col_wren;
    logic [6:0]  cursor_x;
    logic [4:0]  cursor_y;
    logic        busy;

    int checks = 0;
    int errors = 0;

    text_console_writer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .char_data  (char_data),
        .char_attr  (char_attr),
        .wr_addr    (wr_addr),
        .scr_data   (scr_data),
        .scr_wren   (scr_wren),
        .col_data   (col_data),
        .col_wren   (col_wren),
        .cursor_x   (cursor_x),
        .cursor_y   (cursor_y),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] ch, input logic [7:0] at);
        char_valid = 1'b1;
        char_data  = ch;
        char_attr  = at;
        step();
        char_valid = 1'b0;
    endtask

    task automatic check_cursor(input string nm, input logic [6:0] x, input logic [4:0] y);
        check({nm, "_x"}, 32'(cursor_x), 32'(x));
        check({nm, "_y"}, 32'(cursor_y), 32'(y));
    endtask

    // Follow a blank fill starting at {row0,0}, row-major, until char_ready returns.
    task automatic run_clear(input string nm, input int exp_n, input logic [4:0] row0,
                             input logic [7:0] exp_attr);
        int          n;
        int          bad;
        logic        rd;
        logic [11:0] ea;
        logic [11:0] last;
        n    = 0;
        bad  = 0;
        rd   = 1'b0;
        last = '0;
        for (int i = 0; i < 2100; i++) begin
            step();
            if (scr_wren) begin
                ea = {5'(32'(row0) + n / 80), 7'(n % 80)};
                if (col_wren !== 1'b1 || wr_addr !== ea || scr_data !== 8'h20 ||
                    col_data !== exp_attr)
                    bad++;
                last = wr_addr;
                n++;
            end else if (col_wren) begin
                bad++;
            end
            if (char_ready) begin
                rd = 1'b1;
                break;
            end
        end
        check({nm, "_ready"}, 32'(rd), 32'd1);
        check({nm, "_count"}, 32'(n), 32'(exp_n));
        check({nm, "_bad_writes"}, 32'(bad), 32'd0);
        check({nm, "_last_addr"}, 32'(last),
              32'({5'(32'(row0) + (exp_n - 1) / 80), 7'((exp_n - 1) % 80)}));
    endtask

    task automatic wait_idle();
        logic rd;
        rd = char_ready;
        for (int i = 0; i < 2100 && !rd; i++) begin
            step();
            rd = char_ready;
        end
        check("idle_timeout", 32'(rd), 32'd1);
    endtask

    vec_t vecs[10];

    initial begin
        int          n;
        int          bad;
        logic [11:0] ea;

        vecs[0] = '{8'h41, 8'h1F, 1'b1, 12'h000, 8'h41, 8'h1F, 7'd1, 5'd0, 1'b1};
        vecs[1] = '{8'h42, 8'h1F, 1'b1, 12'h001, 8'h42, 8'h1F, 7'd2, 5'd0, 1'b1};
        vecs[2] = '{8'h0D, 8'h00, 1'b0, 12'h000, 8'h00, 8'h00, 7'd0, 5'd0, 1'b1};
        vecs[3] = '{8'h08, 8'h00, 1'b0, 12'h000, 8'h00, 8'h00, 7'd0, 5'd0, 1'b1};
        vecs[4] = '{8'h43, 8'h2E, 1'b1, 12'h000, 8'h43, 8'h2E, 7'd1, 5'd0, 1'b1};
        vecs[5] = '{8'h44, 8'h2E, 1'b1, 12'h001, 8'h44, 8'h2E, 7'd2, 5'd0, 1'b1};
        vecs[6] = '{8'h45, 8'h2E, 1'b1, 12'h002, 8'h45, 8'h2E, 7'd3, 5'd0, 1'b1};
        vecs[7] = '{8'h08, 8'h00, 1'b0, 12'h000, 8'h00, 8'h00, 7'd2, 5'd0, 1'b1};
        vecs[8] = '{8'h08, 8'h00, 1'b0, 12'h000, 8'h00, 8'h00, 7'd1, 5'd0, 1'b1};
        vecs[9] = '{8'h46, 8'h4B, 1'b1, 12'h001, 8'h46, 8'h4B, 7'd2, 5'd0, 1'b1};

        rst_n      = 1'b0;
        char_valid = 1'b0;
        char_data  = 8'h00;
        char_attr  = 8'h00;
        step();
        step();
        step();

        // Reset values
        check("rst_wren", 32'(scr_wren), 32'd0);
        check("rst_col_wren", 32'(col_wren), 32'd0);
        check("rst_addr", 32'(wr_addr), 32'd0);
        check("rst_data", 32'(scr_data), 32'd0);
        check("rst_ready", 32'(char_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);
        check_cursor("rst_cursor", 7'd0, 5'd0);

        rst_n = 1'b1;
        run_clear("boot_clear", 2000, 5'd0, 8'h70);
        check_cursor("boot_cursor", 7'd0, 5'd0);
        check("boot_busy", 32'(busy), 32'd0);
        step();
        check("boot_wren_off", 32'(scr_wren), 32'd0);

        // Table: back-to-back characters and cursor control codes on row 0
        for (int i = 0; i < 10; i++) begin
            send(vecs[i].ch, vecs[i].attr);
            check($sformatf("vec%0d_wren", i), 32'(scr_wren), 32'(vecs[i].exp_wren));
            check($sformatf("vec%0d_col_wren", i), 32'(col_wren), 32'(vecs[i].exp_wren));
            if (vecs[i].exp_wren) begin
                check($sformatf("vec%0d_addr", i), 32'(wr_addr), 32'(vecs[i].exp_addr));
                check($sformatf("vec%0d_data", i), 32'(scr_data), 32'(vecs[i].exp_data));
                check($sformatf("vec%0d_attr", i), 32'(col_data), 32'(vecs[i].exp_attr));
            end
            check_cursor($sformatf("vec%0d", i), vecs[i].exp_x, vecs[i].exp_y);
            check($sformatf("vec%0d_ready", i), 32'(char_ready), 32'(vecs[i].exp_ready));
        end

        // Move to (79,3) then print at end of line
        send(8'h0D, 8'h00);
        for (int i = 0; i < 3; i++) begin
            send(8'h0A, 8'h07);
            wait_idle();
        end
        for (int i = 0; i < 79; i++) send(8'h78, 8'h07);
        check_cursor("eol_pre", 7'd79, 5'd3);
        send(8'h5A, 8'h5A);
        check("eol_wren", 32'(scr_wren), 32'd1);
        check("eol_addr", 32'(wr_addr), 32'h1CF);
        check("eol_data", 32'(scr_data), 32'h5A);
        check("eol_attr", 32'(col_data), 32'h5A);
        check_cursor("eol_post", 7'd0, 5'd4);
        check("eol_ready", 32'(char_ready), 32'd0);
        check("eol_busy", 32'(busy), 32'd1);
        run_clear("eol_clear", 80, 5'd4, 8'h5A);
        check_cursor("eol_after_clear", 7'd0, 5'd4);
        step();
        check("eol_wren_off", 32'(scr_wren), 32'd0);

        // Reach (5,24), then LF wraps to row 0 and clears it
        for (int i = 0; i < 20; i++) begin
            send(8'h0A, 8'h07);
            wait_idle();
        end
        for (int i = 0; i < 5; i++) send(8'h61, 8'h07);
        check_cursor("wrap_pre", 7'd5, 5'd24);
        send(8'h0A, 8'h35);
        check("lf_wren", 32'(scr_wren), 32'd0);
        check_cursor("lf_post", 7'd0, 5'd0);
        check("lf_ready", 32'(char_ready), 32'd0);
        run_clear("lf_clear", 80, 5'd0, 8'h35);
        for (int i = 0; i < 10; i++) send(8'h62, 8'h07);
        check_cursor("cr_pre", 7'd10, 5'd0);
        send(8'h0D, 8'h07);
        check("cr_wren", 32'(scr_wren), 32'd0);
        check_cursor("cr_post", 7'd0, 5'd0);
        check("cr_ready", 32'(char_ready), 32'd1);
        send(8'h08, 8'h07);
        check("bs0_wren", 32'(scr_wren), 32'd0);
        check_cursor("bs0_post", 7'd0, 5'd0);

        // FF mid-screen, reset during the 100th clear write
        send(8'h0A, 8'h07);
        wait_idle();
        for (int i = 0; i < 7; i++) send(8'h63, 8'h07);
        check_cursor("ff_pre", 7'd7, 5'd1);
        send(8'h0C, 8'h3C);
        check("ff_wren", 32'(scr_wren), 32'd0);
        check_cursor("ff_post", 7'd0, 5'd0);
        check("ff_ready", 32'(char_ready), 32'd0);
        check("ff_busy", 32'(busy), 32'd1);
        n   = 0;
        bad = 0;
        for (int i = 0; i < 200 && n < 100; i++) begin
            step();
            if (scr_wren) begin
                ea = {5'(n / 80), 7'(n % 80)};
                if (wr_addr !== ea || scr_data !== 8'h20 || col_data !== 8'h3C) bad++;
                n++;
            end
        end
        check("ff_partial_count", 32'(n), 32'd100);
        check("ff_partial_bad", 32'(bad), 32'd0);
        check("ff_ready_mid", 32'(char_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_wren", 32'(scr_wren), 32'd0);
        check("mid_rst_col_wren", 32'(col_wren), 32'd0);
        check("mid_rst_addr", 32'(wr_addr), 32'd0);
        check_cursor("mid_rst_cursor", 7'd0, 5'd0);
        step();
        step();
        rst_n = 1'b1;
        run_clear("restart_clear", 2000, 5'd0, 8'h70);
        check_cursor("restart_cursor", 7'd0, 5'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
